// File: rtl/counter_updown_mod.sv
// Up/down modulo counter with a programmable limit, wrap or saturate mode,
// per-direction event pulses and software-clearable sticky status flags.
module counter_updown_mod #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] limit,
  input  logic             saturate,
  input  logic             clear_status,
  output logic [WIDTH-1:0] count,
  output logic             ovf_pulse,
  output logic             unf_pulse,
  output logic             overflow_sticky,
  output logic             underflow_sticky,
  output logic             at_limit,
  output logic             at_zero
);

  logic [WIDTH-1:0] count_nxt;
  logic             ovf_ev;
  logic             unf_ev;
  logic             ovf_sticky_nxt;
  logic             unf_sticky_nxt;

  // Next-state: load beats enable; a count above limit is pulled back to
  // limit on a down step without raising an event.
  always_comb begin
    count_nxt = count;
    ovf_ev    = 1'b0;
    unf_ev    = 1'b0;
    if (load) begin
      count_nxt = load_value;
    end else if (enable) begin
      if (up_down) begin
        if (count >= limit) begin
          count_nxt = saturate ? limit : '0;
          ovf_ev    = 1'b1;
        end else begin
          count_nxt = count + WIDTH'(1);
        end
      end else begin
        if (count > limit) begin
          count_nxt = limit;
        end else if (count == '0) begin
          count_nxt = saturate ? '0 : limit;
          unf_ev    = 1'b1;
        end else begin
          count_nxt = count - WIDTH'(1);
        end
      end
    end
    // A same-edge event wins over clear_status.
    ovf_sticky_nxt = ovf_ev | (overflow_sticky  & ~clear_status);
    unf_sticky_nxt = unf_ev | (underflow_sticky & ~clear_status);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count            <= RESET_VALUE;
      ovf_pulse        <= 1'b0;
      unf_pulse        <= 1'b0;
      overflow_sticky  <= 1'b0;
      underflow_sticky <= 1'b0;
    end else begin
      count            <= count_nxt;
      ovf_pulse        <= ovf_ev;
      unf_pulse        <= unf_ev;
      overflow_sticky  <= ovf_sticky_nxt;
      underflow_sticky <= unf_sticky_nxt;
    end
  end

  assign at_limit = (count >= limit);
  assign at_zero  = (count == '0);

endmodule

// File: tb/tb_counter_updown_mod.sv
// Bench for counter_updown_mod: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_counter_updown_mod;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable, up_down, load, saturate, clear_status;
  logic [W-1:0] load_value, limit;
  logic [W-1:0] count;
  logic         ovf_pulse, unf_pulse, overflow_sticky, underflow_sticky;
  logic         at_limit, at_zero;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // model state
  int m_count;
  bit m_ovf, m_unf, m_os, m_us;

  counter_updown_mod #(.WIDTH(W), .RESET_VALUE(8'h00)) dut (
    .clk(clk), .rst(rst), .enable(enable), .up_down(up_down), .load(load),
    .load_value(load_value), .limit(limit), .saturate(saturate),
    .clear_status(clear_status), .count(count), .ovf_pulse(ovf_pulse),
    .unf_pulse(unf_pulse), .overflow_sticky(overflow_sticky),
    .underflow_sticky(underflow_sticky), .at_limit(at_limit), .at_zero(at_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural reference: the counting rules as plain integer arithmetic.
  always @(posedge clk or posedge rst) begin
    bit eo, eu;
    int lim;
    if (rst) begin
      m_count = 0; m_ovf = 0; m_unf = 0; m_os = 0; m_us = 0;
    end else begin
      eo = 0; eu = 0;
      lim = int'(limit);
      if (load) m_count = int'(load_value);
      else if (enable && up_down) begin
        if (m_count >= lim) begin eo = 1; m_count = saturate ? lim : 0; end
        else m_count = m_count + 1;
      end else if (enable) begin
        if (m_count > lim) m_count = lim;
        else if (m_count == 0) begin eu = 1; m_count = saturate ? 0 : lim; end
        else m_count = m_count - 1;
      end
      m_ovf = eo;
      m_unf = eu;
      m_os  = eo || (m_os && !clear_status);
      m_us  = eu || (m_us && !clear_status);
    end
  end

  // Every-cycle comparison, mid-cycle when outputs are settled.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("count", int'(count), m_count);
      chk("ovf_pulse", int'(ovf_pulse), int'(m_ovf));
      chk("unf_pulse", int'(unf_pulse), int'(m_unf));
      chk("overflow_sticky", int'(overflow_sticky), int'(m_os));
      chk("underflow_sticky", int'(underflow_sticky), int'(m_us));
      chk("at_limit", int'(at_limit), int'(m_count >= int'(limit)));
      chk("at_zero", int'(at_zero), int'(m_count == 0));
      chk("pulse_exclusive", int'(ovf_pulse & unf_pulse), 0);
    end
  end

  // Apply one cycle of inputs, then return 1 time unit after the edge.
  task automatic cyc(input bit en, input bit ud, input bit ld,
                     input logic [W-1:0] lv, input bit clr);
    enable = en; up_down = ud; load = ld; load_value = lv; clear_status = clr;
    @(posedge clk); #1;
  endtask

  int exp_up[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int exp_dn[4]  = '{1, 0, 0, 0};

  initial begin
    rst = 1'b1; enable = 0; up_down = 0; load = 0; load_value = '0;
    limit = 8'hFF; saturate = 0; clear_status = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", int'(count), 0);
    chk("reset_ovf", int'(ovf_pulse), 0);
    chk("reset_sticky", int'(overflow_sticky | underflow_sticky), 0);
    rst = 1'b0;
    chk_en = 1'b1;

    // async reset mid-count
    cyc(0, 0, 1, 8'h30, 0);
    repeat (7) cyc(1, 1, 0, 8'h00, 0);
    chk("pre_reset_count", int'(count), 'h37);
    #2 rst = 1'b1;
    #1 chk("async_reset_count", int'(count), 0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, 8'h00, 0);
      chk("hold_count", int'(count), 0);
      chk("hold_pulses", int'(ovf_pulse | unf_pulse), 0);
    end

    // up wrap, limit 9
    limit = 8'd9; saturate = 0;
    cyc(0, 0, 1, 8'h00, 0);
    for (int i = 0; i < 12; i++) begin
      cyc(1, 1, 0, 8'h00, 0);
      chk("upwrap_count", int'(count), exp_up[i]);
      chk("upwrap_ovf", int'(ovf_pulse), int'(i == 9));
    end
    chk("upwrap_sticky", int'(overflow_sticky), 1);

    // down saturate, limit 9
    saturate = 1;
    cyc(0, 0, 1, 8'd2, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 8'h00, 0);
      chk("dnsat_count", int'(count), exp_dn[i]);
      chk("dnsat_unf", int'(unf_pulse), int'(i >= 2));
    end
    chk("dnsat_at_zero", int'(at_zero), 1);

    // load above limit
    limit = 8'd5; saturate = 0;
    cyc(0, 0, 1, 8'hF0, 0);
    cyc(1, 1, 0, 8'h00, 0);
    chk("above_up_count", int'(count), 0);
    chk("above_up_ovf", int'(ovf_pulse), 1);
    cyc(0, 0, 1, 8'hF0, 0);
    cyc(1, 0, 0, 8'h00, 0);
    chk("above_dn_count", int'(count), 5);
    chk("above_dn_pulses", int'(ovf_pulse | unf_pulse), 0);

    // full range
    limit = 8'hFF;
    cyc(0, 0, 1, 8'hFE, 0);
    cyc(1, 1, 0, 8'h00, 0);
    chk("full_ff", int'(count), 'hFF);
    chk("full_ff_ovf", int'(ovf_pulse), 0);
    cyc(1, 1, 0, 8'h00, 0);
    chk("full_00", int'(count), 0);
    chk("full_00_ovf", int'(ovf_pulse), 1);
    cyc(1, 1, 0, 8'h00, 0);
    chk("full_01", int'(count), 1);
    chk("full_01_ovf", int'(ovf_pulse), 0);
    cyc(1, 1, 1, 8'h42, 0);
    chk("load_over_enable", int'(count), 'h42);
    chk("load_no_pulse", int'(ovf_pulse), 0);

    // sticky clear race
    limit = 8'd3;
    cyc(0, 0, 0, 8'h00, 1);
    chk("sticky_cleared", int'(overflow_sticky), 0);
    cyc(0, 0, 1, 8'd3, 0);
    cyc(1, 1, 0, 8'h00, 1);
    chk("race_sticky", int'(overflow_sticky), 1);
    chk("race_ovf", int'(ovf_pulse), 1);
    cyc(0, 0, 0, 8'h00, 1);
    chk("clear_alone", int'(overflow_sticky), 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 3))
          0: limit = 8'h00;
          1: limit = 8'hFF;
          2: limit = W'($urandom_range(1, 6));
          default: limit = W'($urandom);
        endcase
      end
      if ($urandom_range(0, 15) == 0) saturate = ~saturate;
      cyc(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 15) == 0),
          W'($urandom), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
